serial_adder: RTL and testbench

- Bit-serial adder built around the team's `half_adder` cell. Two `half_adder` instances plus an OR form one full-adder slice; a carry flip-flop carries between bits.
- Accepts two WIDTH-bit operands and a carry-in on a start pulse.
- Processes one bit per clock, LSB first, then presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits directly downstream of the `half_adder` cell, consuming its sum/carry outputs each cycle. It is the first sequential arithmetic stage in the lab datapath.

---
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice (two half adders plus an OR) is
// reused once per clock, LSB first. A carry flip-flop links successive bits.
// The result registers update only on the completion edge.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  // Single-bit add without carry-in.
  always_comb begin
    sum   = a ^ b;
    carry = a & b;
  end

endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             ha0_s;
  logic             ha0_c;
  logic             fa_s;
  logic             ha1_c;
  logic             fa_c;

  half_adder u_ha0 (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .sum   (ha0_s),
    .carry (ha0_c)
  );

  half_adder u_ha1 (
    .a     (ha0_s),
    .b     (carry),
    .sum   (fa_s),
    .carry (ha1_c)
  );

  // Full-adder carry: the two half-adder carries can never both be set.
  always_comb begin
    fa_c = ha0_c | ha1_c;
  end

  // Control FSM and datapath; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          psum  <= {fa_s, psum[WIDTH-1:1]};
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Final bit enters straight into sum so the partial value never shows.
            sum   <= {fa_s, psum[WIDTH-1:1]};
            cout  <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: vector table at WIDTH=8, hand-written
// multi-cycle corner sequences, and an exhaustive sweep at WIDTH=4.

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one WIDTH=8 operation; return latency (edges after the start edge
  // until done is seen) and the number of waiting cycles where busy was low.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                     output int lat, output int busy_bad);
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    busy_bad = 0;
    while (!done8 && lat < 40) begin
      if (!busy8) busy_bad++;
      tick();
      lat++;
    end
  endtask

  task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                     output int lat);
    a4 = ia; b4 = ib; cin4 = ic; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bb;
    int dcount;
    int first_done;
    int bad;
    int last_done;
    int gap_bad;
    logic [4:0] ref4;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    // Reset for two cycles.
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_sum",  64'(sum8),  64'd0);
    check("rst_cout", 64'(cout8), 64'd0);
    check("rst_sum4", 64'({cout4, sum4}), 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven WIDTH=8 operations.
    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bb);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd8);
      check($sformatf("v%0d_busy_run", i), 64'(bb), 64'd0);
      check($sformatf("v%0d_busy_at_done", i), 64'(busy8), 64'd0);
      check($sformatf("v%0d_sum", i), 64'(sum8), 64'(vecs[i].s));
      check($sformatf("v%0d_cout", i), 64'(cout8), 64'(vecs[i].c));
      tick();
      check($sformatf("v%0d_done_drop", i), 64'({busy8, done8}), 64'd0);
      check($sformatf("v%0d_sum_hold", i), 64'(sum8), 64'(vecs[i].s));
    end

    // start pulse during the 3rd RUN cycle must be ignored.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    dcount = 0;
    first_done = -1;
    for (int n = 1; n <= 14; n++) begin
      if (n == 3) begin
        a8 = 8'hF0; b8 = 8'hF0; start8 = 1'b1;
      end
      tick();
      start8 = 1'b0;
      if (done8) begin
        dcount++;
        if (first_done < 0) begin
          first_done = n;
          check("ign_sum", 64'(sum8), 64'h02);
          check("ign_cout", 64'(cout8), 64'd0);
        end
      end
    end
    check("ign_done_at", 64'(first_done), 64'd8);
    check("ign_done_count", 64'(dcount), 64'd1);

    // Reset in the 5th RUN cycle aborts the operation.
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int n = 1; n < 5; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    check("abort_sum",  64'(sum8),  64'd0);
    check("abort_cout", 64'(cout8), 64'd0);
    dcount = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done8) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    op8(8'h10, 8'h20, 1'b0, lat, bb);
    check("after_abort_latency", 64'(lat), 64'd8);
    check("after_abort_sum", 64'({cout8, sum8}), 64'h030);
    tick();

    // start held high: a new op accepted on every DONE cycle.
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    dcount = 0;
    bad = 0;
    gap_bad = 0;
    first_done = -1;
    last_done = -1;
    for (int n = 1; n <= 26; n++) begin
      tick();
      if (done8) begin
        dcount++;
        if (first_done < 0) first_done = n;
        else if (n - last_done != 9) gap_bad++;
        last_done = n;
        if (cout8 !== 1'b0) bad++;
      end
      if (first_done >= 0 && sum8 !== 8'h10) bad++;
    end
    start8 = 1'b0;
    check("hold_first_done", 64'(first_done), 64'd8);
    check("hold_pulses", 64'(dcount), 64'd3);
    check("hold_gap", 64'(gap_bad), 64'd0);
    check("hold_sum_stable", 64'(bad), 64'd0);
    tick();
    tick();
    check("hold_idle", 64'({busy8, done8}), 64'd0);
    check("hold_final_sum", 64'(sum8), 64'h10);

    // Exhaustive sweep at WIDTH=4.
    bad = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          op4(4'(ia), 4'(ib), 1'(ic), lat);
          ref4 = 5'(ia + ib + ic);
          check($sformatf("w4_%0h_%0h_%0d_lat", ia, ib, ic), 64'(lat), 64'd4);
          check($sformatf("w4_%0h_%0h_%0d_res", ia, ib, ic), 64'({cout4, sum4}), 64'(ref4));
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
